// File: rtl/msg_serializer.sv
// Parallel-message to AXI4-Stream serializer: one message per handshake, DATA_BYTES per beat, LSB byte first.
// Optional zero-bubble back-to-back acceptance when MSG_SER_BACK2BACK_EN is defined.

module msg_ser_lane (
    input  logic [7:0]  byte_in,
    input  logic [15:0] idx,
    input  logic [15:0] len,
    output logic        keep,
    output logic [7:0]  byte_out
);
    assign keep     = (idx < len);
    assign byte_out = keep ? byte_in : 8'h00;
endmodule

module msg_serializer #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DATA_BYTES    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msg_valid,
    output logic                       msg_ready,
    input  logic [15:0]                msg_length,
    input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
    input  logic                       msg_error,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [8*DATA_BYTES-1:0]    m_tdata,
    output logic [DATA_BYTES-1:0]      m_tkeep,
    output logic                       m_tlast,
    output logic                       m_tuser
);
    localparam int NB = (MAX_MSG_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int CW = $clog2(NB) + 1;
    localparam int BW = 8 * DATA_BYTES;
    localparam int PW = NB * BW;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [NB-1:0][BW-1:0]  msg_q;
    logic [15:0]            len_q;
    logic                   err_q;
    logic [CW-1:0]          beat_q;
    logic [CW-1:0]          last_q;

    logic [NB-1:0][BW-1:0]  in_beats;
    logic                   in_over;
    logic [15:0]            in_len;
    logic                   in_err;
    logic [CW-1:0]          in_last;
    logic                   accept;

    logic [NB-1:0][BW-1:0]  src_beats;
    logic [15:0]            src_len;
    logic                   src_err;
    logic [CW-1:0]          src_last;
    logic [CW-1:0]          src_k;
    logic [BW-1:0]          sel_word;
    logic [BW-1:0]          nxt_data;
    logic [DATA_BYTES-1:0]  nxt_keep;
    logic                   nxt_last;
    logic                   nxt_user;

    // Message is zero-padded to a whole number of beats so every beat slice exists.
    assign in_beats = PW'(msg_data);

    always_comb begin
        in_over = (msg_length > 16'(MAX_MSG_BYTES));
        in_len  = in_over ? 16'(MAX_MSG_BYTES) : msg_length;
        in_err  = msg_error | in_over;
        in_last = CW'((in_len + 16'(DATA_BYTES - 1)) / 16'(DATA_BYTES) - 16'd1);
    end

`ifdef MSG_SER_BACK2BACK_EN
    assign msg_ready = rst && ((state == IDLE) || (m_tvalid && m_tlast && m_tready));
`else
    assign msg_ready = rst && (state == IDLE);
`endif

    assign accept = msg_valid && msg_ready;

    // The next beat comes either from the message being accepted (beat 0) or from the held copy.
    always_comb begin
        src_beats = accept ? in_beats : msg_q;
        src_len   = accept ? in_len   : len_q;
        src_err   = accept ? in_err   : err_q;
        src_last  = accept ? in_last  : last_q;
        src_k     = accept ? '0       : beat_q + 1'b1;
        sel_word  = '0;
        for (int b = 0; b < NB; b++)
            if (src_k == CW'(b))
                sel_word = src_beats[b];
        nxt_last = (src_k == src_last);
        nxt_user = nxt_last & src_err;
    end

    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        logic [15:0] idx;
        assign idx = 16'(src_k) * 16'(DATA_BYTES) + 16'(i);
        msg_ser_lane u_lane (
            .byte_in  (sel_word[8*i +: 8]),
            .idx      (idx),
            .len      (src_len),
            .keep     (nxt_keep[i]),
            .byte_out (nxt_data[8*i +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            msg_q    <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            beat_q   <= '0;
            last_q   <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (accept) begin
            msg_q  <= in_beats;
            len_q  <= in_len;
            err_q  <= in_err;
            last_q <= in_last;
            beat_q <= '0;
            if (in_len != 16'd0) begin
                state    <= SEND;
                m_tvalid <= 1'b1;
                m_tdata  <= nxt_data;
                m_tkeep  <= nxt_keep;
                m_tlast  <= nxt_last;
                m_tuser  <= nxt_user;
            end else begin
                state    <= IDLE;
                m_tvalid <= 1'b0;
                m_tdata  <= '0;
                m_tkeep  <= '0;
                m_tlast  <= 1'b0;
                m_tuser  <= 1'b0;
            end
        end else if (state == SEND && m_tready) begin
            if (m_tlast) begin
                state    <= IDLE;
                m_tvalid <= 1'b0;
                m_tdata  <= '0;
                m_tkeep  <= '0;
                m_tlast  <= 1'b0;
                m_tuser  <= 1'b0;
            end else begin
                beat_q  <= beat_q + 1'b1;
                m_tdata <= nxt_data;
                m_tkeep <= nxt_keep;
                m_tlast <= nxt_last;
                m_tuser <= nxt_user;
            end
        end
    end
endmodule

// File: doc/msg_serializer.md
Name: msg_serializer

Overview:
Transmit-side counterpart of the team's AXI-Stream message parser. It accepts one whole message per handshake as a wide parallel word plus byte length. It then emits that message as an AXI4-Stream master, DATA_BYTES per beat, LSB byte first, with tkeep on the last beat and tlast/tuser framing. It sits between message-producing logic and any AXI-Stream sink, including the parser itself for loopback.

Parameters:
MAX_MSG_BYTES, 32, maximum message size in bytes; width of msg_data is 8*MAX_MSG_BYTES.
DATA_BYTES, 8, stream beat width in bytes; width of m_tdata is 8*DATA_BYTES; MAX_MSG_BYTES >= DATA_BYTES.

Ports:
clk  input  1  single clock; all logic on posedge.
rst  input  1  asynchronous, active-low reset (0 = in reset).
msg_valid  input  1  message offered.
msg_ready  output  1  block can accept a message.
msg_length  input  16  message length in bytes.
msg_data  input  8*MAX_MSG_BYTES  message bytes, byte 0 on [7:0].
msg_error  input  1  message flagged bad; forwarded on tuser.
m_tvalid  output  1  beat valid.
m_tready  input  1  sink accepts beat.
m_tdata  output  8*DATA_BYTES  beat data, lowest-index byte on [7:0].
m_tkeep  output  DATA_BYTES  byte-valid mask.
m_tlast  output  1  last beat of message.
m_tuser  output  1  error flag, meaningful only with m_tlast.

Behaviour:
- Interface: clock clk; reset rst, asynchronous, active-low. All flops clear on negedge rst regardless of clk.
- Reset values: msg_ready=0 while rst=0, then 1 in the first IDLE cycle. m_tvalid, m_tlast, m_tuser = 0. m_tdata and m_tkeep = 0.
- States: IDLE, SEND.
- IDLE: msg_ready=1 and m_tvalid=0.
  - On msg_valid && msg_ready, capture msg_data, the effective length L and the error bit into internal registers.
  - If L > 0, go to SEND. If L == 0, discard the message, emit no beats and stay in IDLE.
- Length rules:
  - L = min(msg_length, MAX_MSG_BYTES).
  - If msg_length > MAX_MSG_BYTES, truncate to MAX_MSG_BYTES and force the error bit to 1.
  - Beat count N = ceil(L/DATA_BYTES). Use a beat counter, width clog2(ceil(MAX_MSG_BYTES/DATA_BYTES))+1.
- SEND:
  - msg_ready=0 and m_tvalid=1.
  - Beat k carries bytes k*DATA_BYTES .. k*DATA_BYTES+DATA_BYTES-1.
  - Non-last beats: m_tkeep all ones, m_tlast=0, m_tuser=0.
  - Last beat (k=N-1): m_tlast=1 and m_tuser=error bit. With r = L mod DATA_BYTES, m_tkeep = (1<<r)-1 if r != 0, else all ones. Bytes with tkeep=0 are driven as 0x00.
- Advance: on m_tvalid && m_tready, step to the next beat. On handshake of the last beat, return to IDLE.
- Latency: message accepted in cycle T; beat 0 valid in cycle T+1. Without the optional feature there is one IDLE cycle between messages.
- Backpressure: while m_tvalid && !m_tready, m_tdata, m_tkeep, m_tlast and m_tuser hold stable. m_tvalid never deasserts before its handshake.
- msg_data and msg_length are sampled only at the accept handshake; later changes have no effect.
- Reset mid-message: the message is dropped and outputs go immediately to reset values. No partial tlast is emitted.

Optional Feature:
Macro MSG_SER_BACK2BACK_EN.
- Defined: msg_ready = IDLE || (SEND && last beat && m_tready). A message accepted during the final-beat handshake starts its beat 0 in the next cycle, giving zero bubble cycles. A length-0 message accepted this way returns to IDLE.
- Undefined: msg_ready=1 only in IDLE, with one bubble between messages as described above.

Test Plan:
All scenarios use defaults (DATA_BYTES=8, MAX_MSG_BYTES=32).
1. msg_length=20, bytes 0x01..0x14, m_tready=1 -> 3 beats in consecutive cycles.
   - beat0 m_tdata=0x0807060504030201, m_tkeep=0xFF.
   - beat1 m_tkeep=0xFF.
   - beat2 m_tdata=0x0000000014131211, m_tkeep=0x0F, m_tlast=1, m_tuser=0.
2. msg_length=8, msg_error=1 -> single beat, m_tkeep=0xFF, m_tlast=1, m_tuser=1. msg_ready=1 again two cycles after accept.
3. msg_length=24, m_tready held 0 for 4 cycles during beat1 -> beat1 m_tdata/m_tkeep/m_tlast unchanged across the stall, msg_ready=0 throughout, 3 beats total.
4. msg_length=40 -> truncated to 4 beats all m_tkeep=0xFF; m_tuser=1 on the tlast beat only.
5. msg_length=0 accepted -> no m_tvalid ever, msg_ready=1 the following cycle.
6. rst driven 0 between clock edges during beat1 of a 32-byte message -> m_tvalid=0 immediately. After release, msg_ready=1 and the next message starts cleanly at beat0. With MSG_SER_BACK2BACK_EN, two 16-byte messages yield 4 consecutive valid beats.
